// File: rtl/pixel_fetcher.sv
// pixel_fetcher: upstream feeder of the display pixel FIFO.
//
// On every accepted frame_start the block walks the framebuffer linearly
// from word 0 to H_RES*V_RES-1. It issues fixed-latency reads and pushes
// the returned RGB words into the pixel FIFO. Reads are only issued while
// FIFO occupancy plus reads in flight is below FIFO_DEPTH, so every
// returning word always has a free FIFO slot.
//
// Ports:
//   clk            single clock
//   rst            synchronous, active-high reset
//   frame_start    one-cycle pulse, starts a frame fetch when idle
//   mem_addr       framebuffer read address (holds last issued value)
//   mem_rd_en      read strobe
//   mem_rdata      read data {R,G,B}, valid MEM_LATENCY cycles after read
//   fifo_level     registered FIFO occupancy
//   fifo_full      FIFO full flag
//   fifo_data      pixel word to the FIFO
//   fifo_wr_en     FIFO write strobe
//   busy           high while fetching or draining
//   frame_done     one-cycle pulse after the last pixel is written
//   frame_overrun  sticky: frame_start arrived while not idle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for frame_start; in_flight is zero
// FETCH | issuing reads whenever credit allows
// DRAIN | all addresses issued, waiting for the last words to be written

module pixel_fetcher #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ADDR_W      = 19,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int LEVEL_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_en,
  input  logic [23:0]        mem_rdata,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic               fifo_full,
  output logic [23:0]        fifo_data,
  output logic               fifo_wr_en,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam int IF_W  = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = LEVEL_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]      pix_cnt, pix_cnt_nxt, issue_addr;
  logic [IF_W-1:0]        in_flight, in_flight_nxt;
  logic [MEM_LATENCY-1:0] vld_pipe;
  logic [SUM_W-1:0]       credit_sum;
  logic                   credit_ok;
  logic                   issue;
  logic                   drain_done;

  // One extra bit so level + in_flight cannot wrap. fifo_full is redundant
  // with the sum when the FIFO reports its level correctly; it is kept as a
  // second guard.
  assign credit_sum = SUM_W'(fifo_level) + SUM_W'(in_flight);
  assign credit_ok  = !fifo_full && (credit_sum < SUM_W'(FIFO_DEPTH));

  assign busy = (state == FETCH) || (state == DRAIN);

  // The read for pixel 0 is issued on the same edge that leaves IDLE, so
  // the first strobe appears in the first FETCH cycle.
  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    issue_addr  = pix_cnt;
    pix_cnt_nxt = pix_cnt;
    drain_done  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt   = FETCH;
          issue_addr  = '0;
          pix_cnt_nxt = '0;
          issue       = credit_ok;
        end
      end
      FETCH: begin
        issue = credit_ok;
      end
      DRAIN: begin
        // No reads are issued here, so the last write empties in_flight.
        if ((in_flight == '0) || ((in_flight == IF_W'(1)) && fifo_wr_en)) begin
          drain_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (issue) begin
      if (issue_addr == LAST_ADDR) begin
        state_nxt   = DRAIN;
        pix_cnt_nxt = issue_addr;
      end else begin
        pix_cnt_nxt = issue_addr + ADDR_W'(1);
      end
    end
  end

  // A word stays in in_flight up to and including its fifo_wr_en cycle; the
  // FIFO counts it from the same edge onward.
  always_comb begin
    in_flight_nxt = in_flight;
    if (issue && !fifo_wr_en) begin
      in_flight_nxt = in_flight + IF_W'(1);
    end else if (!issue && fifo_wr_en) begin
      in_flight_nxt = in_flight - IF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr      <= '0;
      mem_rd_en     <= 1'b0;
      pix_cnt       <= '0;
      in_flight     <= '0;
      vld_pipe      <= '0;
      fifo_data     <= '0;
      fifo_wr_en    <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      mem_rd_en <= issue;
      if (issue) begin
        mem_addr <= issue_addr;
      end
      pix_cnt   <= pix_cnt_nxt;
      in_flight <= in_flight_nxt;
      // The pipe follows the visible strobe, so its top bit marks the cycle
      // in which mem_rdata holds the word for that read.
      vld_pipe   <= (vld_pipe << 1) | MEM_LATENCY'(mem_rd_en);
      fifo_wr_en <= vld_pipe[MEM_LATENCY-1];
      if (vld_pipe[MEM_LATENCY-1]) begin
        fifo_data <= mem_rdata;
      end
      frame_done <= drain_done;
      if (frame_start && (state != IDLE)) begin
        frame_overrun <= 1'b1;
      end
    end
  end

endmodule
